// File: rtl/debounce_scheduler_pkg.sv
// Shared types and helpers for the time-multiplexed switch debouncer.
// FSM encodings and the channel-index width helper live here.
package debounce_scheduler_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Width of the channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/debounce_scheduler_sync_2ff.sv
// Two-flop synchronizer for one raw switch input.
// Resets to 0 asynchronously.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/debounce_scheduler.sv
// N-channel debouncer sharing one prescaler; each sample tick starts a scan
// that evaluates one channel per clock and emits 1-cycle rise/fall pulses.
module debounce_scheduler
  import debounce_scheduler_pkg::*;
#(
  parameter int N          = 4,
  parameter int PRESCALE_W = 16,
  parameter int PRESCALE   = 10000,
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic [N-1:0] in,
  output logic [N-1:0] out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         tick,
  output logic         overrun
);

  localparam int                    IDX_W   = idx_width(N);
  localparam logic [PRESCALE_W-1:0] PRE_MAX = PRESCALE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0]      CNT_MAX = CNT_W'(STABLE_CNT - 1);
  localparam logic [IDX_W-1:0]      IDX_MAX = IDX_W'(N - 1);

  logic [N-1:0]          w_s;
  logic [N-1:0]          w_sel;
  logic                  w_tick;
  logic [PRESCALE_W-1:0] r_pre;
  state_t                r_state;
  state_t                w_state_next;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_next;
  logic                  r_overrun;
  logic [N-1:0]          r_out;
  logic [N-1:0]          r_rise;
  logic [N-1:0]          r_fall;
  logic [CNT_W-1:0]      r_cnt [N];

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (in[gi]),
        .o_q   (w_s[gi])
      );
      assign w_sel[gi] = (r_state == ST_SCAN) && (r_idx == IDX_W'(gi));
    end
  endgenerate

  assign w_tick = enable && (r_pre == PRE_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
    end else if (!enable || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      // A tick during a scan is dropped; only the sticky flag records it.
      if (w_tick && (r_state == ST_SCAN)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          w_state_next = ST_SCAN;
          w_idx_next   = '0;
        end
      end
      ST_SCAN: begin
        if (r_idx == IDX_MAX) begin
          w_state_next = ST_IDLE;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  // Only the channel selected by the scan index can change in a given cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < N; i++) begin
        if (w_sel[i]) begin
          if (w_s[i] == r_out[i]) begin
            r_cnt[i] <= '0;
          end else if (r_cnt[i] == CNT_MAX) begin
            r_out[i]  <= w_s[i];
            r_cnt[i]  <= '0;
            r_rise[i] <= w_s[i];
            r_fall[i] <= ~w_s[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign out     = r_out;
  assign rise    = r_rise;
  assign fall    = r_fall;
  assign tick    = w_tick;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Bench for debounce_scheduler: main instance (N=4, PRESCALE=8, STABLE_CNT=3)
// against a per-tick reference model, plus a PRESCALE=3 instance for overrun.
module tb_debounce_scheduler;

  localparam int N  = 4;
  localparam int PS = 8;
  localparam int SC = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, enable;
  logic [N-1:0] in_v, out, rise, fall;
  logic         tick, overrun;

  logic         rst2_n;
  logic [N-1:0] in2, out2, rise2, fall2;
  logic         tick2, ov2;

  debounce_scheduler #(.N(N), .PRESCALE_W(16), .PRESCALE(PS), .STABLE_CNT(SC), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .in(in_v), .out(out),
    .rise(rise), .fall(fall), .tick(tick), .overrun(overrun)
  );

  debounce_scheduler #(.N(N), .PRESCALE_W(16), .PRESCALE(3), .STABLE_CNT(SC), .CNT_W(3)) dut_ov (
    .clk(clk), .rst_n(rst2_n), .enable(1'b1), .in(in2), .out(out2),
    .rise(rise2), .fall(fall2), .tick(tick2), .overrun(ov2)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [N-1:0] m_out;
  int           m_cnt [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_out = '0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic wait_tick(output int edges);
    edges = 0;
    do begin
      step();
      edges++;
    end while (!tick && edges < 40);
    if (!tick) check("tick_timeout", 32'(tick), 1);
  endtask

  // One sample tick: wait for it, apply the debounce rules to the held input,
  // then check outputs and pulses on each cycle of the scan that follows.
  task automatic do_tick(input string tag, output int edges);
    logic [N-1:0] old_out, new_out, chg, e_out, e_rise, e_fall;
    wait_tick(edges);
    old_out = m_out;
    new_out = m_out;
    chg     = '0;
    for (int i = 0; i < N; i++) begin
      if (in_v[i] == m_out[i]) m_cnt[i] = 0;
      else if (m_cnt[i] < SC - 1) m_cnt[i]++;
      else begin
        new_out[i] = in_v[i];
        chg[i]     = 1'b1;
        m_cnt[i]   = 0;
      end
    end
    for (int k = 1; k <= N + 1; k++) begin
      step();
      e_rise = '0;
      e_fall = '0;
      for (int i = 0; i < N; i++) begin
        e_out[i] = (i <= k - 2) ? new_out[i] : old_out[i];
        if (i == k - 2 && chg[i]) begin
          e_rise[i] = new_out[i];
          e_fall[i] = ~new_out[i];
        end
      end
      check({tag, "_out"},  32'(out),  32'(e_out));
      check({tag, "_rise"}, 32'(rise), 32'(e_rise));
      check({tag, "_fall"}, 32'(fall), 32'(e_fall));
      check({tag, "_tick"}, 32'(tick), 0);
    end
    m_out = new_out;
    $display("tick %s in=%b out=%b chg=%b", tag, in_v, m_out, chg);
  endtask

  initial begin
    int e;
    rst_n  = 1'b0;
    rst2_n = 1'b0;
    enable = 1'b1;
    in_v   = '0;
    in2    = '0;
    model_reset();
    repeat (3) step();
    check("rst_out", 32'(out), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_ovr", 32'(overrun), 0);

    rst_n = 1'b1;
    do_tick("first", e);
    check("first_tick_lat", e, PS - 1);

    // Single channel rising.
    in_v = 4'b0100;
    repeat (3) do_tick("rise2", e);
    check("rise2_final", 32'(out), 32'h4);

    // Bounce: two high samples, one low, two high never reach three in a row.
    in_v = 4'b0110; repeat (2) do_tick("bnc_hi", e);
    in_v = 4'b0100; do_tick("bnc_lo", e);
    in_v = 4'b0110; repeat (2) do_tick("bnc_hi2", e);
    check("bounce_final", 32'(out), 32'h4);
    in_v = 4'b0100; do_tick("bnc_clr", e);

    // All channels together: pulses step through channels one per cycle.
    in_v = 4'b0000; repeat (3) do_tick("all_lo", e);
    in_v = 4'b1111; repeat (3) do_tick("all_hi", e);
    check("all_final", 32'(out), 32'hF);
    check("period", 5 + e, PS);

    // Disabled prescaler: no ticks, output frozen while inputs toggle.
    enable = 1'b0;
    for (int c = 0; c < 50; c++) begin
      in_v = 4'($urandom);
      step();
      check("dis_tick", 32'(tick), 0);
      check("dis_out", 32'(out), 32'(m_out));
    end
    in_v   = 4'($urandom);
    enable = 1'b1;
    do_tick("reen", e);
    check("reen_lat", e, PS - 1);

    // Randomized held inputs.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) in_v = 4'($urandom);
      do_tick("rnd", e);
      check("rnd_period", 5 + e, PS);
    end

    // Reset in the middle of a scan.
    in_v = 4'b1010;
    repeat (3) do_tick("pre_rst", e);
    check("pre_rst_out", 32'(out), 32'hA);
    in_v = 4'b0101;
    wait_tick(e);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out", 32'(out), 0);
    check("mid_rst_rise", 32'(rise), 0);
    check("mid_rst_fall", 32'(fall), 0);
    check("mid_rst_tick", 32'(tick), 0);
    check("mid_rst_ovr", 32'(overrun), 0);
    step();
    step();
    rst_n = 1'b1;
    model_reset();
    do_tick("post_rst", e);
    check("post_rst_lat", e, PS - 1);
    repeat (3) do_tick("post_rst2", e);
    check("post_rst_final", 32'(out), 32'h5);
    check("main_no_ovr", 32'(overrun), 0);

    // Short prescaler: ticks arrive mid-scan and set the sticky flag.
    in2    = 4'b1111;
    rst2_n = 1'b1;
    check("ov_rst", 32'(ov2), 0);
    e = 0;
    do begin
      step();
      e++;
    end while (!tick2 && e < 20);
    check("ov_tick_seen", 32'(tick2), 1);
    check("ov_first_tick", 32'(ov2), 0);
    repeat (4) step();
    check("ov_set", 32'(ov2), 1);
    for (int c = 0; c < 40; c++) begin
      step();
      if (c % 10 == 9) check("ov_sticky", 32'(ov2), 1);
    end
    check("ov_scans_done", 32'(out2), 32'hF);
    check("ov_fall", 32'(fall2), 0);
    check("ov_rise", 32'(rise2), 0);
    rst2_n = 1'b0;
    #1;
    check("ov_clear", 32'(ov2), 0);
    check("ov_clear_out", 32'(out2), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
